exe_stage_mc: RTL
=================

# exe_stage_mc

Parametrised multi-cycle execute stage for the TP4 pipeline. It sits between the ID/EX and EX/MEM registers. It resolves operand forwarding from the MEM and WB stages, executes single-cycle ALU operations, and runs an iterative unsigned multiply/divide unit. A valid/ready handshake on both sides lets it stall the front end while a multi-cycle operation is in flight.

## Interface
Parameters:
- W, 32: data width; must be ≥ 8 and a power of two.
- RW, 5: register index width.
- SHW, $clog2(W): shift-amount width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID/EX holds an operation.
- in_ready  out  1  stage accepts the operation this cycle.
- id_op  in  4  operation code (see Operation).
- id_a, id_b  in  W  register-file operands for rs/rt.
- id_imm  in  W  sign/zero-extended immediate.
- id_use_imm  in  1  operand B = id_imm.
- id_rs, id_rt, id_rd  in  RW  source and destination indices.
- id_wr  in  1  operation writes the register file.
- mem_rd, wb_rd  in  RW  destination indices in MEM and WB.
- mem_wr, wb_wr  in  1  MEM/WB will write.
- mem_fwd, wb_fwd  in  W  MEM ALU result and WB write data.
- out_valid  out  1  result registers hold a completed operation.
- out_ready  in  1  EX/MEM consumes the result.
- out_result  out  W  ALU result, product low word, or quotient.
- out_hi  out  W  product high word or remainder; 0 for single-cycle ops.
- out_rd  out  RW  destination index.
- out_wr  out  1  register write enable (copied from id_wr).
- busy  out  1  multiply/divide iteration in progress.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift A by B[SHW-1:0].
  - 11 MUL: unsigned, 2W-bit result split {out_hi, out_result}.
  - 12 DIV: unsigned restoring; quotient → out_result, remainder → out_hi.
  - 13–15: reserved; out_result = 0, out_hi = 0.
- Forwarding for A, evaluated combinationally in the accept cycle:
  - If mem_wr && mem_rd == id_rs && id_rs != 0: use mem_fwd.
  - Else if wb_wr && wb_rd == id_rs && id_rs != 0: use wb_fwd.
  - Else: use id_a.
  - MEM always has priority over WB. Register 0 is never forwarded.
- Forwarding for B uses the same rule on id_rt, unless id_use_imm = 1, in which case B = id_imm.
- Resolved operands, op, rd and wr are latched at acceptance. Later changes on the forwarding inputs have no effect on the accepted operation.
- State machine:
  - IDLE → HOLD: accept of ops 0–10 or 13–15.
  - IDLE → BUSY: accept of MUL/DIV; counter loads W.
  - BUSY: one multiply (shift-add) or divide (shift-subtract) step per cycle. Counter decrements.
  - BUSY → HOLD: after the step where the counter reaches 0.
  - HOLD → IDLE: out_ready && !in_valid.
  - HOLD → HOLD or BUSY: out_ready && in_valid, i.e. back-to-back accept.
  - HOLD with !out_ready: outputs frozen.
- in_ready = (state == IDLE) || (state == HOLD && out_ready). in_ready is 0 while BUSY.
- out_valid = (state == HOLD). busy = (state == BUSY).
- Divide by zero: the algorithm runs unmodified and yields quotient all-ones and remainder = dividend. No exception flag.
- Arithmetic is modulo 2^W. No overflow detection.

## Timing
- Reset (rst = 0, asynchronous):
  - State becomes IDLE; counter = 0.
  - out_valid, out_result, out_hi, out_rd, out_wr and busy = 0.
  - in_ready is 1 immediately after release.
  - Reset mid-BUSY or mid-HOLD discards the operation.
- Single-cycle op accepted at edge N: out_valid = 1 after edge N, giving latency 1. Throughput is 1 per cycle when out_ready is held at 1.
- MUL/DIV accepted at edge N: busy = 1 after edges N … N+W−1. out_valid = 1 after edge N+W, giving latency W. in_ready = 0 for those W cycles.
- Simultaneous out_ready and in_valid in HOLD: the old result is consumed and the new operation is accepted on the same edge, with no bubble.
- Forwarding inputs are sampled only in the cycle where in_valid && in_ready.

## Test plan
- Reset:
  - Stimulus: pulse rst low mid-MUL, at busy cycle 10.
  - Required: all outputs 0 asynchronously; in_ready = 1 after release; no stale out_valid.
- ALU and forwarding priority:
  - Stimulus: ADD with id_rs = 3, id_a = 5, mem_wr = 1, mem_rd = 3, mem_fwd = 100, wb_wr = 1, wb_rd = 3, wb_fwd = 7, id_b = 1.
  - Required: out_result = 101 one cycle later.
  - Repeat with id_rs = 0: out_result = 6.
- Multiply:
  - Stimulus: MUL 0xFFFF_FFFF × 0x0000_0002 with W = 32.
  - Required: out_hi = 1 and out_result = 0xFFFF_FFFE after exactly 32 cycles.
  - in_ready = 0 and busy = 1 throughout the iteration.
- Divide:
  - Stimulus: DIV 100 / 7.
  - Required: out_result = 14, out_hi = 2 after 32 cycles.
  - Stimulus: DIV 9 / 0.
  - Required: out_result = 0xFFFF_FFFF, out_hi = 9.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles after an SRA of 0x8000_0000 by 4.
  - Required: out_result stays 0xF800_0000, in_ready = 0 during the hold.
  - Required on the edge out_ready rises with in_valid = 1: the next op is accepted with no bubble.
- Throughput:
  - Stimulus: 8 consecutive single-cycle ops, out_ready = 1.
  - Required: 8 results on 8 consecutive cycles, in order.

Source files
------------

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: operand forwarding, single-cycle ALU and an
// iterative unsigned multiply/divide unit behind valid/ready handshakes.
//
//  state | meaning
//  IDLE  | no operation held, ready to accept
//  BUSY  | multiply/divide iterating, one step per cycle
//  HOLD  | result registers valid, waiting for out_ready
module exe_stage_mc #(
    parameter int W   = 32,
    parameter int RW  = 5,
    parameter int SHW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    id_op,
    input  logic [W-1:0]  id_a,
    input  logic [W-1:0]  id_b,
    input  logic [W-1:0]  id_imm,
    input  logic          id_use_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_wr,
    input  logic [RW-1:0] mem_rd,
    input  logic [RW-1:0] wb_rd,
    input  logic          mem_wr,
    input  logic          wb_wr,
    input  logic [W-1:0]  mem_fwd,
    input  logic [W-1:0]  wb_fwd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [W-1:0]  out_hi,
    output logic [RW-1:0] out_rd,
    output logic          out_wr,
    output logic          busy
);

    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} stateT;

    stateT          state, nextState;
    logic [CW-1:0]  cnt;
    logic           isDiv;
    logic [W-1:0]   opnd;
    logic [W-1:0]   resLo, resHi;
    logic [RW-1:0]  rdReg;
    logic           wrReg;

    logic [W-1:0]   fwdA, fwdB, aluRes;
    logic [SHW-1:0] shAmt;
    logic           accept, isMulti;
    logic [W:0]     mulSum, divShift, divDiff;

    // MEM beats WB; register 0 is hard-wired and never forwarded.
    always_comb begin
        fwdA = id_a;
        if (id_rs != '0 && mem_wr && mem_rd == id_rs)     fwdA = mem_fwd;
        else if (id_rs != '0 && wb_wr && wb_rd == id_rs)  fwdA = wb_fwd;
        fwdB = id_b;
        if (id_use_imm)                                   fwdB = id_imm;
        else if (id_rt != '0 && mem_wr && mem_rd == id_rt) fwdB = mem_fwd;
        else if (id_rt != '0 && wb_wr && wb_rd == id_rt)   fwdB = wb_fwd;
    end

    assign shAmt   = fwdB[SHW-1:0];
    assign isMulti = (id_op == OP_MUL) || (id_op == OP_DIV);
    assign accept  = in_valid && in_ready;

    always_comb begin
        aluRes = '0;
        case (id_op)
            OP_ADD:  aluRes = fwdA + fwdB;
            OP_SUB:  aluRes = fwdA - fwdB;
            OP_AND:  aluRes = fwdA & fwdB;
            OP_OR:   aluRes = fwdA | fwdB;
            OP_XOR:  aluRes = fwdA ^ fwdB;
            OP_NOR:  aluRes = ~(fwdA | fwdB);
            OP_SLT:  aluRes = W'($signed(fwdA) < $signed(fwdB));
            OP_SLTU: aluRes = W'(fwdA < fwdB);
            OP_SLL:  aluRes = fwdA << shAmt;
            OP_SRL:  aluRes = fwdA >> shAmt;
            OP_SRA:  aluRes = $unsigned($signed(fwdA) >>> shAmt);
            default: aluRes = '0;
        endcase
    end

    // Multiply keeps the multiplier in resLo and shifts the product in from
    // the top; divide shifts the dividend out of resLo into the remainder.
    assign mulSum   = {1'b0, resHi} + (resLo[0] ? {1'b0, opnd} : '0);
    assign divShift = {resHi, resLo[W-1]};
    assign divDiff  = divShift - {1'b0, opnd};

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = isMulti ? BUSY : HOLD;
            end
            BUSY: begin
                if (cnt == CW'(1)) nextState = HOLD;
            end
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) nextState = in_valid ? (isMulti ? BUSY : HOLD) : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            isDiv <= 1'b0;
            opnd  <= '0;
            resLo <= '0;
            resHi <= '0;
            rdReg <= '0;
            wrReg <= 1'b0;
        end else if (accept) begin
            rdReg <= id_rd;
            wrReg <= id_wr;
            resHi <= '0;
            if (isMulti) begin
                cnt   <= CW'(W);
                isDiv <= (id_op == OP_DIV);
                resLo <= (id_op == OP_DIV) ? fwdA : fwdB;
                opnd  <= (id_op == OP_DIV) ? fwdB : fwdA;
            end else begin
                resLo <= aluRes;
            end
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            if (isDiv) begin
                if (!divDiff[W]) begin
                    resHi <= divDiff[W-1:0];
                    resLo <= {resLo[W-2:0], 1'b1};
                end else begin
                    resHi <= divShift[W-1:0];
                    resLo <= {resLo[W-2:0], 1'b0};
                end
            end else begin
                resHi <= mulSum[W:1];
                resLo <= {mulSum[0], resLo[W-1:1]};
            end
        end
    end

    assign out_valid  = (state == HOLD);
    assign busy       = (state == BUSY);
    assign out_result = resLo;
    assign out_hi     = resHi;
    assign out_rd     = rdReg;
    assign out_wr     = wrReg;

endmodule
